// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (core, debug) arbiter in front of a single-port
// data memory. Each access runs IDLE -> GRANT -> (RESP) -> IDLE.
// A read returns data and an rvalid pulse two cycles after its grant. A write
// completes during its grant cycle.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration on a tie.
// When it is undefined, core wins every tie and no pointer register exists.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  // state | meaning
  // IDLE  | waiting for a request; the winner is latched on the edge
  // GRANT | one-cycle grant; the memory sees the latched access
  // RESP  | read data arrives from memory and is registered at the closing edge
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              id_q, id_d;          // 0 = core, 1 = dbg
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic              win_dbg;

`ifdef DMEM_ARB_RR_EN
  logic prio_q, prio_d;                  // requester preferred on the next tie (0 = core)

  // Tie goes to whichever requester did not win last time
  always_comb begin
    win_dbg = dbg_req & (~core_req | prio_q);
    prio_d  = prio_q;
    if (state_q == IDLE && (core_req || dbg_req)) prio_d = ~win_dbg;
  end

  // Round-robin pointer, starts out preferring core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  // Fixed priority: core always wins a tie
  always_comb begin
    win_dbg = dbg_req & ~core_req;
  end
`endif

  // Next-state logic and capture of the winning request
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    core_rdata_d  = core_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req || dbg_req) begin
          state_d = GRANT;
          id_d    = win_dbg;
          we_d    = win_dbg ? dbg_we    : core_we;
          addr_d  = win_dbg ? dbg_addr  : core_addr;
          wdata_d = win_dbg ? dbg_wdata : core_wdata;
        end
      end
      GRANT: state_d = we_q ? IDLE : RESP;
      RESP: begin
        state_d = IDLE;
        if (id_q) begin
          dbg_rdata_d  = mem_q;
          dbg_rvalid_d = 1'b1;
        end else begin
          core_rdata_d  = mem_q;
          core_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

  assign core_gnt    = (state_q == GRANT) & ~id_q;
  assign dbg_gnt     = (state_q == GRANT) &  id_q;
  assign mem_wren    = (state_q == GRANT) &  we_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign core_rvalid = core_rvalid_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports core_req / core_we, input, 1 each, core access request and write-enable.
REQ-006 SHALL have ports core_addr, input, ADDR_W, and core_wdata, input, DATA_W, core address and store data.
REQ-007 SHALL have ports core_gnt / core_rvalid, output, 1 each, grant pulse and read-data-valid pulse.
REQ-008 SHALL have port core_rdata, output, DATA_W, core load data.
REQ-009 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, same directions and widths as the core_* ports, debug/loader requester.
REQ-010 SHALL have ports mem_address, output, ADDR_W; mem_data, output, DATA_W; mem_wren, output, 1: drive the single-port data memory.
REQ-011 SHALL have port mem_q, input, DATA_W, memory read data, valid in the cycle after the address edge.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, RESP.
REQ-013 In IDLE with any req high at a clock edge, SHALL latch the winner's id, we, addr, and wdata, then enter GRANT.
REQ-014 In GRANT, SHALL assert the winner's gnt for exactly one cycle and drive mem_address/mem_data from the latch; mem_wren = latched we.
REQ-015 From GRANT, SHALL go to RESP if latched we=0, else to IDLE.
REQ-016 In RESP, SHALL register mem_q into the winner's rdata at the closing edge, then pulse that port's rvalid for one cycle while back in IDLE.
REQ-017 Read latency SHALL be: req sampled at edge E, gnt during cycle E+1, rvalid and rdata during cycle E+3; write gnt during cycle E+1 with mem_wren in the same cycle.
REQ-018 Requester SHALL hold req/we/addr/wdata stable until its gnt; the arbiter SHALL ignore req outside IDLE.
REQ-019 Req still high in the IDLE cycle after a transaction SHALL start a new transaction (back-to-back).
REQ-020 SHALL assert at most one gnt, and at most one rvalid, in any cycle.
REQ-021 rdata of each port SHALL hold its last value until its next read completes.
REQ-022 Outside GRANT, mem_wren SHALL be 0; mem_address/mem_data SHALL hold the last latched values.
REQ-023 Simultaneous core_req and dbg_req SHALL be resolved per REQ-028/029; the loser stays pending with no gnt.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and set all gnt, rvalid, and mem_wren to 0, all rdata to 0, mem_address/mem_data to 0, and the round-robin pointer to core.
REQ-025 Reset during GRANT or RESP SHALL abort the transaction; no rvalid SHALL follow it, and a write whose GRANT edge never occurred SHALL not be performed.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to sample requests normally.

Configuration
REQ-027 Macro DMEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-028 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie the requester that did not win last gets the grant, and the pointer updates on every grant.
REQ-029 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed priority, with core always winning a tie; no pointer register SHALL exist.

Verification
REQ-030 Core write then read: core_we=1, addr=0x10, wdata=0xDEADBEEF, then read 0x10 -> core_gnt in cycle E+1 with mem_wren=1, and read core_rvalid at E+3 with core_rdata=0xDEADBEEF.
REQ-031 Debug read of preloaded addr 0xFF=0x12345678 -> dbg_rvalid at E+3, dbg_rdata=0x12345678, core_rvalid stays 0.
REQ-032 Both req held continuously, reads: with RR_EN -> grants alternate core, dbg, core, dbg; without it -> core granted every transaction and dbg never granted.
REQ-033 Back-to-back core reads of 0x01 then 0x02 with req held -> second gnt 3 cycles after the first (read) and 2 cycles after the first (write), and no idle bubble beyond the FSM.
REQ-034 rst_n pulsed low during RESP of a dbg read -> no dbg_rvalid, all outputs 0, and the next core write at 0x20 completes normally.
REQ-035 A dbg write to 0x30 aborted by reset in GRANT before the edge -> a subsequent read of 0x30 returns its prior contents.
